// File: rtl/tlb_mp_lookup.sv
// rtl/tlb_mp_lookup.sv - multi-port MIPS32 joint TLB with lookup, write, read, probe and Random/Wired
// Optional multi-match detection on each lookup channel: TLB_MULTIHIT_CHECK_EN
module tlb_mp_lookup #(
    parameter int  ENTRY_NUM    = 16,
    parameter int  LOOKUP_PORTS = 2,
    localparam int IDX_W        = $clog2(ENTRY_NUM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    asid,
    input  logic [LOOKUP_PORTS-1:0]       lk_req,
    input  logic [LOOKUP_PORTS*32-1:0]    lk_vaddr,
    output logic [LOOKUP_PORTS-1:0]       lk_valid,
    output logic [LOOKUP_PORTS*32-1:0]    lk_paddr,
    output logic [LOOKUP_PORTS-1:0]       lk_miss,
    output logic [LOOKUP_PORTS-1:0]       lk_v,
    output logic [LOOKUP_PORTS-1:0]       lk_d,
    output logic [LOOKUP_PORTS*3-1:0]     lk_c,
    output logic [LOOKUP_PORTS*IDX_W-1:0] lk_index,
    input  logic                          we,
    input  logic [IDX_W-1:0]              w_index,
    input  logic [31:0]                   w_hi,
    input  logic [31:0]                   w_lo0,
    input  logic [31:0]                   w_lo1,
    input  logic [IDX_W-1:0]              rd_index,
    output logic [31:0]                   rd_hi,
    output logic [31:0]                   rd_lo0,
    output logic [31:0]                   rd_lo1,
    input  logic                          probe_req,
    input  logic [31:0]                   probe_hi,
    output logic                          probe_done,
    output logic                          probe_miss,
    output logic [IDX_W-1:0]              probe_index,
    input  logic                          wired_we,
    input  logic [IDX_W-1:0]              wired_i,
`ifdef TLB_MULTIHIT_CHECK_EN
    output logic [LOOKUP_PORTS-1:0]       multihit,
`endif
    output logic [IDX_W-1:0]              random_o
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(ENTRY_NUM - 1);

    logic [18:0] vpn2_q [ENTRY_NUM];
    logic [7:0]  asid_q [ENTRY_NUM];
    logic        g_q    [ENTRY_NUM];
    logic [19:0] pfn0_q [ENTRY_NUM];
    logic [19:0] pfn1_q [ENTRY_NUM];
    logic [2:0]  c0_q   [ENTRY_NUM];
    logic [2:0]  c1_q   [ENTRY_NUM];
    logic        d0_q   [ENTRY_NUM];
    logic        d1_q   [ENTRY_NUM];
    logic        v0_q   [ENTRY_NUM];
    logic        v1_q   [ENTRY_NUM];

    logic [ENTRY_NUM-1:0] lk_match [LOOKUP_PORTS];
    logic [ENTRY_NUM-1:0] probe_match;
    logic                 lk_hit   [LOOKUP_PORTS];
    logic [IDX_W-1:0]     lk_idx   [LOOKUP_PORTS];
    logic                 probe_hit;
    logic [IDX_W-1:0]     probe_idx;

    logic [LOOKUP_PORTS-1:0]       lk_valid_q, lk_valid_d;
    logic [LOOKUP_PORTS*32-1:0]    lk_paddr_q, lk_paddr_d;
    logic [LOOKUP_PORTS-1:0]       lk_miss_q, lk_miss_d;
    logic [LOOKUP_PORTS-1:0]       lk_v_q, lk_v_d;
    logic [LOOKUP_PORTS-1:0]       lk_d_q, lk_d_d;
    logic [LOOKUP_PORTS*3-1:0]     lk_c_q, lk_c_d;
    logic [LOOKUP_PORTS*IDX_W-1:0] lk_index_q, lk_index_d;
`ifdef TLB_MULTIHIT_CHECK_EN
    logic [LOOKUP_PORTS-1:0]       multihit_q, multihit_d;
`endif
    logic [31:0]      rd_hi_q, rd_lo0_q, rd_lo1_q;
    logic             probe_done_q, probe_miss_q;
    logic [IDX_W-1:0] probe_index_q;
    logic [IDX_W-1:0] random_q, random_d, wired_q, wired_d;

    logic unused_bits;
    assign unused_bits = ^{w_hi[12:8], w_lo0[31:26], w_lo1[31:26], probe_hi[12:8]};

    // Scanning from the top down leaves the lowest matching index in the result.
    function automatic logic [IDX_W:0] prio_enc(input logic [ENTRY_NUM-1:0] m);
        logic [IDX_W:0] r;
        r = '0;
        for (int k = ENTRY_NUM - 1; k >= 0; k--) begin
            if (m[k]) r = {1'b1, IDX_W'(k)};
        end
        return r;
    endfunction

    always_comb begin
        probe_match = '0;
        for (int p = 0; p < LOOKUP_PORTS; p++) lk_match[p] = '0;
        for (int k = 0; k < ENTRY_NUM; k++) begin
            for (int p = 0; p < LOOKUP_PORTS; p++) begin
                lk_match[p][k] = (vpn2_q[k] == lk_vaddr[32*p+13 +: 19]) &&
                                 ((asid_q[k] == asid) || g_q[k]);
            end
            probe_match[k] = (vpn2_q[k] == probe_hi[31:13]) &&
                             ((asid_q[k] == probe_hi[7:0]) || g_q[k]);
        end
    end

    always_comb begin
        for (int p = 0; p < LOOKUP_PORTS; p++) begin
            {lk_hit[p], lk_idx[p]} = prio_enc(lk_match[p]);
        end
        {probe_hit, probe_idx} = prio_enc(probe_match);
    end

    always_comb begin
        lk_valid_d = lk_req;
        lk_paddr_d = lk_paddr_q;
        lk_miss_d  = lk_miss_q;
        lk_v_d     = lk_v_q;
        lk_d_d     = lk_d_q;
        lk_c_d     = lk_c_q;
        lk_index_d = lk_index_q;
`ifdef TLB_MULTIHIT_CHECK_EN
        multihit_d = multihit_q;
`endif
        for (int p = 0; p < LOOKUP_PORTS; p++) begin
            if (lk_req[p]) begin
                lk_miss_d[p]              = !lk_hit[p];
                lk_paddr_d[32*p +: 32]    = '0;
                lk_v_d[p]                 = 1'b0;
                lk_d_d[p]                 = 1'b0;
                lk_c_d[3*p +: 3]          = '0;
                lk_index_d[IDX_W*p +: IDX_W] = '0;
                if (lk_hit[p]) begin
                    lk_index_d[IDX_W*p +: IDX_W] = lk_idx[p];
                    if (lk_vaddr[32*p+12]) begin
                        lk_paddr_d[32*p +: 32] = {pfn1_q[lk_idx[p]], lk_vaddr[32*p +: 12]};
                        lk_c_d[3*p +: 3]       = c1_q[lk_idx[p]];
                        lk_d_d[p]              = d1_q[lk_idx[p]];
                        lk_v_d[p]              = v1_q[lk_idx[p]];
                    end else begin
                        lk_paddr_d[32*p +: 32] = {pfn0_q[lk_idx[p]], lk_vaddr[32*p +: 12]};
                        lk_c_d[3*p +: 3]       = c0_q[lk_idx[p]];
                        lk_d_d[p]              = d0_q[lk_idx[p]];
                        lk_v_d[p]              = v0_q[lk_idx[p]];
                    end
                end
`ifdef TLB_MULTIHIT_CHECK_EN
                multihit_d[p] = ($countones(lk_match[p]) > 1);
`endif
            end
        end
    end

    // Random reloads at or below Wired, which also pins it at the top when Wired >= top.
    always_comb begin
        wired_d  = wired_q;
        random_d = (random_q <= wired_q) ? TOP_IDX : random_q - 1'b1;
        if (wired_we) begin
            wired_d  = wired_i;
            random_d = TOP_IDX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ENTRY_NUM; k++) begin
                vpn2_q[k] <= '0;
                asid_q[k] <= '0;
                g_q[k]    <= 1'b0;
                pfn0_q[k] <= '0;
                pfn1_q[k] <= '0;
                c0_q[k]   <= '0;
                c1_q[k]   <= '0;
                d0_q[k]   <= 1'b0;
                d1_q[k]   <= 1'b0;
                v0_q[k]   <= 1'b0;
                v1_q[k]   <= 1'b0;
            end
        end else if (we) begin
            vpn2_q[w_index] <= w_hi[31:13];
            asid_q[w_index] <= w_hi[7:0];
            g_q[w_index]    <= w_lo0[0] & w_lo1[0];
            pfn0_q[w_index] <= w_lo0[25:6];
            pfn1_q[w_index] <= w_lo1[25:6];
            c0_q[w_index]   <= w_lo0[5:3];
            c1_q[w_index]   <= w_lo1[5:3];
            d0_q[w_index]   <= w_lo0[2];
            d1_q[w_index]   <= w_lo1[2];
            v0_q[w_index]   <= w_lo0[1];
            v1_q[w_index]   <= w_lo1[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lk_valid_q    <= '0;
            lk_paddr_q    <= '0;
            lk_miss_q     <= '0;
            lk_v_q        <= '0;
            lk_d_q        <= '0;
            lk_c_q        <= '0;
            lk_index_q    <= '0;
`ifdef TLB_MULTIHIT_CHECK_EN
            multihit_q    <= '0;
`endif
            rd_hi_q       <= '0;
            rd_lo0_q      <= '0;
            rd_lo1_q      <= '0;
            probe_done_q  <= 1'b0;
            probe_miss_q  <= 1'b0;
            probe_index_q <= '0;
            wired_q       <= '0;
            random_q      <= TOP_IDX;
        end else begin
            lk_valid_q    <= lk_valid_d;
            lk_paddr_q    <= lk_paddr_d;
            lk_miss_q     <= lk_miss_d;
            lk_v_q        <= lk_v_d;
            lk_d_q        <= lk_d_d;
            lk_c_q        <= lk_c_d;
            lk_index_q    <= lk_index_d;
`ifdef TLB_MULTIHIT_CHECK_EN
            multihit_q    <= multihit_d;
`endif
            rd_hi_q       <= {vpn2_q[rd_index], 5'd0, asid_q[rd_index]};
            rd_lo0_q      <= {6'd0, pfn0_q[rd_index], c0_q[rd_index], d0_q[rd_index],
                              v0_q[rd_index], g_q[rd_index]};
            rd_lo1_q      <= {6'd0, pfn1_q[rd_index], c1_q[rd_index], d1_q[rd_index],
                              v1_q[rd_index], g_q[rd_index]};
            probe_done_q  <= probe_req;
            if (probe_req) begin
                probe_miss_q  <= !probe_hit;
                probe_index_q <= probe_hit ? probe_idx : '0;
            end
            wired_q       <= wired_d;
            random_q      <= random_d;
        end
    end

    assign lk_valid    = lk_valid_q;
    assign lk_paddr    = lk_paddr_q;
    assign lk_miss     = lk_miss_q;
    assign lk_v        = lk_v_q;
    assign lk_d        = lk_d_q;
    assign lk_c        = lk_c_q;
    assign lk_index    = lk_index_q;
`ifdef TLB_MULTIHIT_CHECK_EN
    assign multihit    = multihit_q;
`endif
    assign rd_hi       = rd_hi_q;
    assign rd_lo0      = rd_lo0_q;
    assign rd_lo1      = rd_lo1_q;
    assign probe_done  = probe_done_q;
    assign probe_miss  = probe_miss_q;
    assign probe_index = probe_index_q;
    assign random_o    = random_q;

endmodule

// File: tb/tb_tlb_mp_lookup.sv
// tb/tb_tlb_mp_lookup.sv - directed self-checking bench for tlb_mp_lookup
module tb_tlb_mp_lookup;

    localparam int N  = 16;
    localparam int P  = 2;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    asid;
    logic [P-1:0]  lk_req;
    logic [P*32-1:0] lk_vaddr;
    logic [P-1:0]  lk_valid;
    logic [P*32-1:0] lk_paddr;
    logic [P-1:0]  lk_miss, lk_v, lk_d;
    logic [P*3-1:0]  lk_c;
    logic [P*IW-1:0] lk_index;
    logic          we;
    logic [IW-1:0] w_index;
    logic [31:0]   w_hi, w_lo0, w_lo1;
    logic [IW-1:0] rd_index;
    logic [31:0]   rd_hi, rd_lo0, rd_lo1;
    logic          probe_req;
    logic [31:0]   probe_hi;
    logic          probe_done, probe_miss;
    logic [IW-1:0] probe_index;
    logic          wired_we;
    logic [IW-1:0] wired_i;
    logic [IW-1:0] random_o;
`ifdef TLB_MULTIHIT_CHECK_EN
    logic [P-1:0]  multihit;
`endif

    int n_checks = 0;
    int n_errors = 0;

    tlb_mp_lookup #(.ENTRY_NUM(N), .LOOKUP_PORTS(P)) dut (
        .clk(clk), .rst(rst), .asid(asid),
        .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_valid(lk_valid),
        .lk_paddr(lk_paddr), .lk_miss(lk_miss), .lk_v(lk_v), .lk_d(lk_d),
        .lk_c(lk_c), .lk_index(lk_index),
        .we(we), .w_index(w_index), .w_hi(w_hi), .w_lo0(w_lo0), .w_lo1(w_lo1),
        .rd_index(rd_index), .rd_hi(rd_hi), .rd_lo0(rd_lo0), .rd_lo1(rd_lo1),
        .probe_req(probe_req), .probe_hi(probe_hi), .probe_done(probe_done),
        .probe_miss(probe_miss), .probe_index(probe_index),
        .wired_we(wired_we), .wired_i(wired_i),
`ifdef TLB_MULTIHIT_CHECK_EN
        .multihit(multihit),
`endif
        .random_o(random_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [IW-1:0] idx, input logic [31:0] hi,
                               input logic [31:0] lo0, input logic [31:0] lo1);
        we = 1'b1; w_index = idx; w_hi = hi; w_lo0 = lo0; w_lo1 = lo1;
        step();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; asid = 8'd0; lk_req = '0; lk_vaddr = '0; we = 1'b0; w_index = '0;
        w_hi = '0; w_lo0 = '0; w_lo1 = '0; rd_index = '0; probe_req = 1'b0; probe_hi = '0;
        wired_we = 1'b0; wired_i = '0;
        #2;
        step();
        check("rst_lk_valid", 32'(lk_valid), 32'h0);
        check("rst_paddr", lk_paddr[31:0], 32'h0);
        check("rst_probe_done", 32'(probe_done), 32'h0);
        check("rst_rd_lo0", rd_lo0, 32'h0);
        rst = 1'b0;

        for (int i = 0; i <= 16; i++) begin
            check($sformatf("random_seq%0d", i), 32'(random_o), (i == 16) ? 32'd15 : 32'(15 - i));
            step();
        end

        // entry 3: VPN2 0x201 ASID 5, page0 PFN 0x12345 C3 D V, page1 PFN 0x0ABCD V
        write_entry(4'd3, 32'h0040_2005, 32'h0048_D15E, 32'h002A_F342);
        asid = 8'd5; lk_req = 2'b11; lk_vaddr = {32'h0040_3ABC, 32'h0040_2ABC};
        step();
        check("hit_valid", 32'(lk_valid), 32'h3);
        check("hit_p0_paddr", lk_paddr[31:0], 32'h1234_5ABC);
        check("hit_p0_c", 32'(lk_c[2:0]), 32'd3);
        check("hit_p0_d", 32'(lk_d[0]), 32'd1);
        check("hit_p0_v", 32'(lk_v[0]), 32'd1);
        check("hit_p0_idx", 32'(lk_index[3:0]), 32'd3);
        check("hit_p0_miss", 32'(lk_miss[0]), 32'd0);
        check("hit_p1_paddr", lk_paddr[63:32], 32'h0ABC_DABC);
        check("hit_p1_c", 32'(lk_c[5:3]), 32'd0);
        check("hit_p1_d", 32'(lk_d[1]), 32'd0);
        check("hit_p1_v", 32'(lk_v[1]), 32'd1);

        lk_req = 2'b00;
        step();
        check("hold_valid", 32'(lk_valid), 32'h0);
        check("hold_paddr", lk_paddr[31:0], 32'h1234_5ABC);

        asid = 8'd6; lk_req = 2'b01; lk_vaddr = {32'h0, 32'h0040_2ABC};
        step();
        check("asid_miss", 32'(lk_miss[0]), 32'd1);
        check("asid_miss_paddr", lk_paddr[31:0], 32'h0);
        check("asid_miss_v", 32'(lk_v[0]), 32'd0);
        lk_req = 2'b00;

        write_entry(4'd3, 32'h0040_2005, 32'h0048_D15F, 32'h002A_F343);
        lk_req = 2'b01;
        step();
        check("global_hit", 32'(lk_miss[0]), 32'd0);
        check("global_paddr", lk_paddr[31:0], 32'h1234_5ABC);

        // write new PFN 0x55555 in the same cycle as lookups on both channels
        lk_req = 2'b11; lk_vaddr = {32'h0040_2ABC, 32'h0040_2ABC};
        we = 1'b1; w_index = 4'd3; w_hi = 32'h0040_2005; w_lo0 = 32'h0155_555F; w_lo1 = 32'h002A_F343;
        step();
        we = 1'b0;
        check("order_t_p0", lk_paddr[31:0], 32'h1234_5ABC);
        check("order_t_p1", lk_paddr[63:32], 32'h1234_5ABC);
        step();
        check("order_t1_p0", lk_paddr[31:0], 32'h5555_5ABC);
        check("order_t1_p1", lk_paddr[63:32], 32'h5555_5ABC);
        lk_req = 2'b00;

        write_entry(4'd9, 32'h0040_2005, 32'h0044_4442, 32'h0000_0002);
        write_entry(4'd2, 32'h0040_2005, 32'h0088_8882, 32'h0000_0002);
        asid = 8'd5; lk_req = 2'b11; lk_vaddr = {32'h1234_5000, 32'h0040_2ABC};
        step();
        check("prio_idx", 32'(lk_index[3:0]), 32'd2);
        check("prio_paddr", lk_paddr[31:0], 32'h2222_2ABC);
        check("prio_p1_miss", 32'(lk_miss[1]), 32'd1);
        check("prio_p1_idx", 32'(lk_index[7:4]), 32'd0);
`ifdef TLB_MULTIHIT_CHECK_EN
        check("multihit_p0", 32'(multihit[0]), 32'd1);
        check("multihit_p1", 32'(multihit[1]), 32'd0);
`endif
        lk_req = 2'b00;
        write_entry(4'd2, 32'h0080_0005, 32'h0088_8882, 32'h0000_0002);
        lk_req = 2'b01;
        step();
        check("prio_next_idx", 32'(lk_index[3:0]), 32'd3);
        check("prio_next_paddr", lk_paddr[31:0], 32'h5555_5ABC);
        lk_req = 2'b00;

        probe_req = 1'b1; probe_hi = 32'h0040_2005;
        step();
        check("probe_done", 32'(probe_done), 32'd1);
        check("probe_idx", 32'(probe_index), 32'd3);
        check("probe_miss", 32'(probe_miss), 32'd0);
        probe_hi = 32'h7FFF_E005;
        step();
        check("probe2_done", 32'(probe_done), 32'd1);
        check("probe2_miss", 32'(probe_miss), 32'd1);
        check("probe2_idx", 32'(probe_index), 32'd0);
        probe_hi = 32'h00C0_0005;
        we = 1'b1; w_index = 4'd9; w_hi = 32'h00C0_0005; w_lo0 = 32'h2; w_lo1 = 32'h2;
        step();
        we = 1'b0;
        check("probe_prewrite_miss", 32'(probe_miss), 32'd1);
        step();
        check("probe_postwrite_idx", 32'(probe_index), 32'd9);
        probe_req = 1'b0;
        step();
        check("probe_idle_done", 32'(probe_done), 32'd0);

        rd_index = 4'd3;
        step();
        check("rd_hi", rd_hi, 32'h0040_2005);
        check("rd_lo0", rd_lo0, 32'h0155_555F);
        check("rd_lo1", rd_lo1, 32'h002A_F343);

        wired_we = 1'b1; wired_i = 4'd12;
        step();
        wired_we = 1'b0;
        check("wired12_a", 32'(random_o), 32'd15);
        step(); check("wired12_b", 32'(random_o), 32'd14);
        step(); check("wired12_c", 32'(random_o), 32'd13);
        step(); check("wired12_d", 32'(random_o), 32'd12);
        step(); check("wired12_e", 32'(random_o), 32'd15);

        wired_we = 1'b1; wired_i = 4'd15;
        step();
        wired_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wired15_hold%0d", i), 32'(random_o), 32'd15);
            step();
        end

        wired_we = 1'b1; wired_i = 4'd0;
        step();
        wired_we = 1'b0;
        step();
        step();
        check("pre_rst_random", 32'(random_o), 32'd13);
        rst = 1'b1; lk_req = 2'b11; probe_req = 1'b1;
        step();
        rst = 1'b0; lk_req = 2'b00; probe_req = 1'b0;
        check("midrst_random", 32'(random_o), 32'd15);
        check("midrst_lk_valid", 32'(lk_valid), 32'h0);
        check("midrst_probe_done", 32'(probe_done), 32'd0);

        asid = 8'd0; lk_req = 2'b01; lk_vaddr = '0;
        step();
        check("post_rst_valid", 32'(lk_valid[0]), 32'd1);
        check("post_rst_miss", 32'(lk_miss[0]), 32'd0);
        check("post_rst_idx", 32'(lk_index[3:0]), 32'd0);
        check("post_rst_v", 32'(lk_v[0]), 32'd0);
        check("post_rst_rd_hi", rd_hi, 32'h0);
        lk_req = 2'b00;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
